// File: rtl/keycode_player_ctrl_if.sv
// Bus bundle between the SoC keycode/VGA side and the player/harpoon
// controller. The master drives keycode, vsync and the collision pulse and
// receives the per-frame sprite state; the slave is the controller.
interface keycode_player_ctrl_if;
    logic [7:0] keycode;
    logic       vsync_n;
    logic       harpoon_hit;
    logic [9:0] player_x;
    logic       harpoon_active;
    logic [9:0] harpoon_x;
    logic [9:0] harpoon_y;
    logic [7:0] shots;

    modport master (
        output keycode, vsync_n, harpoon_hit,
        input  player_x, harpoon_active, harpoon_x, harpoon_y, shots
    );

    modport slave (
        input  keycode, vsync_n, harpoon_hit,
        output player_x, harpoon_active, harpoon_x, harpoon_y, shots
    );
endinterface

// File: rtl/keycode_player_ctrl.sv
// Bubble Trouble player/harpoon controller. Turns the USB keycode into player
// movement and harpoon launches, advancing once per video frame on the
// synchronised falling edge of vsync. Harpoon hits from the collision logic
// end the shot immediately; a short cooldown follows every shot.
module keycode_player_ctrl #(
    parameter int         SCREEN_W        = 640,
    parameter int         PLAYER_W        = 32,
    parameter int         STEP            = 4,
    parameter int         FLOOR_Y         = 440,
    parameter int         HARPOON_SPEED   = 6,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter logic [7:0] KEY_LEFT        = 8'h04,
    parameter logic [7:0] KEY_RIGHT       = 8'h07,
    parameter logic [7:0] KEY_FIRE        = 8'h2C
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    keycode_player_ctrl_if.slave  bus
);

    localparam int         CNT_W    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] MAX_X_W = 11'(SCREEN_W - PLAYER_W);
    localparam logic [9:0]  START_X = 10'((SCREEN_W - PLAYER_W) / 2);
    localparam logic [9:0]  HALF_W  = 10'(PLAYER_W / 2);
    localparam logic [9:0]  FLOOR_W = 10'(FLOOR_Y);
    localparam logic [9:0]  SPEED_W = 10'(HARPOON_SPEED);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXTEND   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    logic             s1_r, s2_r, s3_r;
    logic             tick_s;
    logic [7:0]       prev_key_r;
    logic             fire_req_r;
    logic             fire_edge_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [9:0]       player_x_r;
    logic             harpoon_active_r;
    logic [9:0]       harpoon_x_r;
    logic [9:0]       harpoon_y_r;
    logic [7:0]       shots_r;
    logic [10:0]      px_ext_s;
    logic [10:0]      px_sum_s;
    logic [9:0]       next_x_s;

    // One-cycle frame tick from the falling edge of the synchronised vsync.
    assign tick_s      = s3_r & ~s2_r;
    assign fire_edge_s = (bus.keycode == KEY_FIRE) && (prev_key_r != KEY_FIRE);

    // Synchronise vsync and latch a fresh space press until the next tick.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_r       <= 1'b1;
            s2_r       <= 1'b1;
            s3_r       <= 1'b1;
            prev_key_r <= 8'h00;
            fire_req_r <= 1'b0;
        end else begin
            s1_r       <= bus.vsync_n;
            s2_r       <= s1_r;
            s3_r       <= s2_r;
            prev_key_r <= bus.keycode;
            if (tick_s) begin
                fire_req_r <= 1'b0;
            end else if (fire_edge_s) begin
                fire_req_r <= 1'b1;
            end
        end
    end

    // Candidate player position for this frame, saturating at both walls.
    always_comb begin
        px_ext_s = {1'b0, player_x_r};
        px_sum_s = px_ext_s + STEP_W;
        next_x_s = player_x_r;
        case (bus.keycode)
            KEY_LEFT: begin
                if (px_ext_s < STEP_W) begin
                    next_x_s = 10'd0;
                end else begin
                    next_x_s = player_x_r - STEP_W[9:0];
                end
            end
            KEY_RIGHT: begin
                if (px_sum_s > MAX_X_W) begin
                    next_x_s = MAX_X_W[9:0];
                end else begin
                    next_x_s = px_sum_s[9:0];
                end
            end
            default: begin
                next_x_s = player_x_r;
            end
        endcase
    end

    // Player movement applies on every tick regardless of harpoon state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            player_x_r <= START_X;
        end else if (tick_s) begin
            player_x_r <= next_x_s;
        end
    end

    // Harpoon state machine: launch, climb, early stop on hit, cooldown.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r          <= IDLE;
            cnt_r            <= '0;
            harpoon_active_r <= 1'b0;
            harpoon_x_r      <= 10'd0;
            harpoon_y_r      <= FLOOR_W;
            shots_r          <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tick_s && fire_req_r) begin
                        state_r          <= EXTEND;
                        harpoon_active_r <= 1'b1;
                        harpoon_x_r      <= player_x_r + HALF_W;
                        harpoon_y_r      <= FLOOR_W;
                        shots_r          <= shots_r + 8'd1;
                    end
                end
                EXTEND: begin
                    if (bus.harpoon_hit) begin
                        // A hit wins over a coincident tick; the tip stays put.
                        state_r          <= COOLDOWN;
                        harpoon_active_r <= 1'b0;
                        cnt_r            <= '0;
                    end else if (tick_s) begin
                        if (harpoon_y_r <= SPEED_W) begin
                            state_r          <= COOLDOWN;
                            harpoon_active_r <= 1'b0;
                            harpoon_y_r      <= 10'd0;
                            cnt_r            <= '0;
                        end else begin
                            harpoon_y_r <= harpoon_y_r - SPEED_W;
                        end
                    end
                end
                COOLDOWN: begin
                    if (tick_s) begin
                        if (cnt_r == CNT_LAST) begin
                            state_r     <= IDLE;
                            harpoon_y_r <= FLOOR_W;
                            cnt_r       <= '0;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    harpoon_active_r <= 1'b0;
                    harpoon_y_r      <= FLOOR_W;
                    cnt_r            <= '0;
                end
            endcase
        end
    end

    assign bus.player_x       = player_x_r;
    assign bus.harpoon_active = harpoon_active_r;
    assign bus.harpoon_x      = harpoon_x_r;
    assign bus.harpoon_y      = harpoon_y_r;
    assign bus.shots          = shots_r;

endmodule

// File: tb/tb_keycode_player_ctrl.sv
// Self-checking bench for keycode_player_ctrl: directed scenarios from the
// test plan plus randomized frames checked against a frame-level model.
module tb_keycode_player_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    keycode_player_ctrl_if bus ();

    keycode_player_ctrl dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Frame-level reference model (game rules, counted in frames).
    int m_px, m_hx, m_hy, m_shots, m_cd, m_prev_k;
    bit m_fly;

    task automatic model_reset();
        m_px = 304; m_hx = 0; m_hy = 440; m_shots = 0;
        m_cd = 0; m_fly = 1'b0; m_prev_k = 0;
    endtask

    task automatic model_frame(input int k, input bit tap, input int h);
        bit fire;
        int px0;
        fire = (k == 'h2C) ? (m_prev_k != 'h2C) : tap;
        if (h == 1 && m_fly) begin m_fly = 1'b0; m_cd = 8; end
        px0 = m_px;
        if (k == 'h04)      m_px = (m_px < 4) ? 0 : m_px - 4;
        else if (k == 'h07) m_px = (m_px + 4 > 608) ? 608 : m_px + 4;
        if (m_fly) begin
            if (h == 2)           begin m_fly = 1'b0; m_cd = 8; end
            else if (m_hy <= 6)   begin m_hy = 0; m_fly = 1'b0; m_cd = 8; end
            else                  m_hy = m_hy - 6;
        end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) m_hy = 440;
        end else if (fire) begin
            m_fly = 1'b1; m_hx = px0 + 16; m_hy = 440;
            m_shots = (m_shots + 1) % 256;
        end
        m_prev_k = k;
    endtask

    function automatic logic [38:0] got_vec();
        return {bus.player_x, bus.harpoon_active, bus.harpoon_x, bus.harpoon_y, bus.shots};
    endfunction

    function automatic logic [38:0] want_vec();
        return {10'(m_px), m_fly, 10'(m_hx), 10'(m_hy), 8'(m_shots)};
    endfunction

    function automatic string fmt(input logic [38:0] v);
        return $sformatf("px=%0d act=%0d hx=%0d hy=%0d shots=%0d",
                         v[38:29], v[28], v[27:18], v[17:8], v[7:0]);
    endfunction

    // One video frame: key held, optional one-clock space tap, optional hit
    // (h=1 between ticks, h=2 in the tick cycle). Returns just after the
    // update edge so outputs can be sampled.
    task automatic run_frame(input logic [7:0] k, input bit tap, input int h);
        bus.keycode = k;
        bus.vsync_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        if (tap) begin
            bus.keycode = 8'h2C; @(posedge clk); #1;
            bus.keycode = k;     @(posedge clk); #1;
        end
        if (h == 1) begin
            bus.harpoon_hit = 1'b1; @(posedge clk); #1;
            bus.harpoon_hit = 1'b0;
        end
        @(posedge clk); #1;
        bus.vsync_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (h == 2) bus.harpoon_hit = 1'b1;
        @(posedge clk); #1;
        bus.harpoon_hit = 1'b0;
        bus.vsync_n = 1'b1;
        model_frame(int'(k), tap, h);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.keycode = 8'h00; bus.vsync_n = 1'b1; bus.harpoon_hit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        tests_run++;
        if (got_vec() !== {10'd304, 1'b0, 10'd0, 10'd440, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got %s, want px=304 act=0 hx=0 hy=440 shots=0", fmt(got_vec()));
        end
        for (int i = 0; i < 10; i++) begin
            run_frame(8'h00, 1'b0, 0);
            tests_run++;
            if (got_vec() !== {10'd304, 1'b0, 10'd0, 10'd440, 8'd0}) begin
                tests_failed++;
                $display("FAIL idle_frame_%0d: got %s, want px=304 act=0 hx=0 hy=440 shots=0", i, fmt(got_vec()));
            end
        end
    endtask

    task automatic test_move();
        int exp_x;
        exp_x = 304;
        for (int i = 0; i < 80; i++) begin
            run_frame(8'h04, 1'b0, 0);
            exp_x = (exp_x < 4) ? 0 : exp_x - 4;
            tests_run++;
            if (bus.player_x !== 10'(exp_x)) begin
                tests_failed++;
                $display("FAIL move_left_%0d: got px=%0d, want %0d", i, bus.player_x, exp_x);
            end
        end
        for (int i = 0; i < 160; i++) begin
            run_frame(8'h07, 1'b0, 0);
            exp_x = (exp_x + 4 > 608) ? 608 : exp_x + 4;
            tests_run++;
            if (bus.player_x !== 10'(exp_x)) begin
                tests_failed++;
                $display("FAIL move_right_%0d: got px=%0d, want %0d", i, bus.player_x, exp_x);
            end
        end
        for (int i = 0; i < 76; i++) run_frame(8'h04, 1'b0, 0);
        tests_run++;
        if (bus.player_x !== 10'd304) begin
            tests_failed++;
            $display("FAIL move_return: got px=%0d, want 304", bus.player_x);
        end
    endtask

    task automatic test_launch();
        run_frame(8'h00, 1'b1, 0);
        tests_run++;
        if (got_vec() !== {10'd304, 1'b1, 10'd320, 10'd440, 8'd1}) begin
            tests_failed++;
            $display("FAIL launch: got %s, want px=304 act=1 hx=320 hy=440 shots=1", fmt(got_vec()));
        end
        for (int i = 0; i < 73; i++) run_frame(8'h00, 1'b0, 0);
        tests_run++;
        if (bus.harpoon_y !== 10'd2 || bus.harpoon_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL climb_73: got hy=%0d act=%0d, want hy=2 act=1", bus.harpoon_y, bus.harpoon_active);
        end
        run_frame(8'h00, 1'b0, 0);
        tests_run++;
        if (bus.harpoon_y !== 10'd0 || bus.harpoon_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL top_reached: got hy=%0d act=%0d, want hy=0 act=0", bus.harpoon_y, bus.harpoon_active);
        end
        for (int i = 0; i < 7; i++) run_frame(8'h00, 1'b0, 0);
        tests_run++;
        if (bus.harpoon_y !== 10'd0) begin
            tests_failed++;
            $display("FAIL cooldown_7: got hy=%0d, want 0", bus.harpoon_y);
        end
        run_frame(8'h00, 1'b0, 0);
        tests_run++;
        if (bus.harpoon_y !== 10'd440 || bus.harpoon_x !== 10'd320) begin
            tests_failed++;
            $display("FAIL cooldown_done: got hy=%0d hx=%0d, want hy=440 hx=320", bus.harpoon_y, bus.harpoon_x);
        end
    endtask

    task automatic test_hold();
        int s0;
        s0 = int'(bus.shots);
        for (int i = 0; i < 200; i++) run_frame(8'h2C, 1'b0, 0);
        tests_run++;
        if (bus.shots !== 8'(s0 + 1) || bus.harpoon_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_space: got shots=%0d act=%0d, want shots=%0d act=0", bus.shots, bus.harpoon_active, s0 + 1);
        end
        run_frame(8'h00, 1'b0, 0);
        run_frame(8'h00, 1'b0, 0);
        run_frame(8'h2C, 1'b0, 0);
        tests_run++;
        if (bus.shots !== 8'(s0 + 2) || bus.harpoon_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL repress_space: got shots=%0d act=%0d, want shots=%0d act=1", bus.shots, bus.harpoon_active, s0 + 2);
        end
        for (int i = 0; i < 82; i++) run_frame(8'h00, 1'b0, 0);
        tests_run++;
        if (got_vec() !== want_vec()) begin
            tests_failed++;
            $display("FAIL hold_model: got %s, want %s", fmt(got_vec()), fmt(want_vec()));
        end
    endtask

    task automatic test_hit();
        int s0;
        run_frame(8'h00, 1'b1, 0);
        s0 = int'(bus.shots);
        for (int i = 0; i < 9; i++) run_frame(8'h00, 1'b0, 0);
        run_frame(8'h07, 1'b0, 2);
        tests_run++;
        if (bus.harpoon_y !== 10'd386 || bus.harpoon_active !== 1'b0 || bus.player_x !== 10'd308) begin
            tests_failed++;
            $display("FAIL hit_on_tick: got hy=%0d act=%0d px=%0d, want hy=386 act=0 px=308",
                     bus.harpoon_y, bus.harpoon_active, bus.player_x);
        end
        run_frame(8'h00, 1'b0, 0);
        run_frame(8'h00, 1'b0, 0);
        run_frame(8'h00, 1'b1, 0);
        tests_run++;
        if (bus.shots !== 8'(s0) || bus.harpoon_active !== 1'b0 || bus.harpoon_y !== 10'd386) begin
            tests_failed++;
            $display("FAIL fire_in_cooldown: got shots=%0d act=%0d hy=%0d, want shots=%0d act=0 hy=386",
                     bus.shots, bus.harpoon_active, bus.harpoon_y, s0);
        end
        for (int i = 0; i < 5; i++) run_frame(8'h00, 1'b0, 0);
        tests_run++;
        if (bus.harpoon_y !== 10'd440) begin
            tests_failed++;
            $display("FAIL hit_cooldown_done: got hy=%0d, want 440", bus.harpoon_y);
        end
    endtask

    task automatic test_random();
        logic [7:0] k;
        bit tap;
        int h, r;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: k = 8'h00;
                1: k = 8'h04;
                2: k = 8'h07;
                3: k = 8'h2C;
                4: k = 8'h04;
                default: k = 8'($urandom_range(0, 255));
            endcase
            tap = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 9);
            h = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            run_frame(k, tap, h);
            tests_run++;
            if (got_vec() !== want_vec()) begin
                tests_failed++;
                $display("FAIL random_frame_%0d (k=%h tap=%0d h=%0d): got %s, want %s",
                         i, k, tap, h, fmt(got_vec()), fmt(want_vec()));
            end
        end
    endtask

    task automatic test_reset_mid();
        run_frame(8'h00, 1'b1, 0);
        for (int i = 0; i < 5; i++) run_frame(8'h07, 1'b0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (got_vec() !== {10'd304, 1'b0, 10'd0, 10'd440, 8'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: got %s, want px=304 act=0 hx=0 hy=440 shots=0", fmt(got_vec()));
        end
        bus.keycode = 8'h04;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        repeat (12) @(posedge clk);
        #1;
        tests_run++;
        if (got_vec() !== {10'd304, 1'b0, 10'd0, 10'd440, 8'd0}) begin
            tests_failed++;
            $display("FAIL no_tick_on_release: got %s, want px=304 act=0 hx=0 hy=440 shots=0", fmt(got_vec()));
        end
        run_frame(8'h04, 1'b0, 0);
        tests_run++;
        if (got_vec() !== want_vec()) begin
            tests_failed++;
            $display("FAIL after_reset_frame: got %s, want %s", fmt(got_vec()), fmt(want_vec()));
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_launch();
        test_hold();
        test_hit();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keycode_player_ctrl.md
Name: keycode_player_ctrl

Overview:
Consumes the 8-bit USB keycode exported by the lab7soc Platform Designer system and the VGA vertical sync. Produces, once per video frame, the Bubble Trouble player's horizontal position and the harpoon's state and geometry for the drawing and collision logic. Sits between the SoC keycode PIO and the sprite renderer. Also exports a shot counter for the hex display path.

Parameters:
SCREEN_W, 640, visible width in pixels
PLAYER_W, 32, player sprite width in pixels
STEP, 4, player pixels moved per frame
FLOOR_Y, 440, harpoon base row
HARPOON_SPEED, 6, harpoon rows climbed per frame
COOLDOWN_FRAMES, 8, frames after a harpoon ends before re-fire is allowed
KEY_LEFT, 8'h04, keycode for move left ('A')
KEY_RIGHT, 8'h07, keycode for move right ('D')
KEY_FIRE, 8'h2C, keycode for fire (space)

Ports:
clk_clk  in  1  system clock, 50 MHz
reset_reset_n  in  1  asynchronous active-low reset
keycode  in  8  current keycode from SoC PIO; 0 when no key is pressed
vsync_n  in  1  raw VGA vsync, active-low, asynchronous to logic
harpoon_hit  in  1  one-cycle pulse from collision logic: harpoon struck a bubble
player_x  out  10  left edge of player sprite
harpoon_active  out  1  high while the harpoon is extending
harpoon_x  out  10  harpoon column
harpoon_y  out  10  harpoon tip row
shots  out  8  launches since reset, wraps 255 -> 0

Behaviour:
- Reset values: player_x = (SCREEN_W-PLAYER_W)/2 = 304; harpoon_active = 0; harpoon_x = 0; harpoon_y = FLOOR_Y; shots = 0; FSM = IDLE; sync flops = 1; fire_req = 0; cooldown count = 0.
- Frame tick:
  - vsync_n passes through 3 flops (s1, s2, s3).
  - tick = s3 & ~s2, a one-cycle pulse on each falling edge of vsync.
  - All frame updates occur on the tick edge, so outputs change on the 3rd clock edge after vsync_n falls is captured.
- Fire edge detect:
  - keycode is registered every clock as prev.
  - (keycode == KEY_FIRE && prev != KEY_FIRE) sets fire_req.
  - fire_req clears on every tick, whether it was consumed or discarded.
  - Holding space does not auto-repeat.
- Movement, on tick:
  - KEY_LEFT: player_x = (player_x < STEP) ? 0 : player_x - STEP.
  - KEY_RIGHT: player_x = (player_x + STEP > SCREEN_W-PLAYER_W) ? SCREEN_W-PLAYER_W : player_x + STEP.
  - Any other keycode: player_x holds.
  - All compares use 11-bit arithmetic; no wrap.
  - Movement continues in every FSM state.
- FSM:
  - IDLE, on tick with fire_req: go to EXTEND. Set harpoon_active = 1, harpoon_x = player_x + PLAYER_W/2 (value before this tick's movement), harpoon_y = FLOOR_Y, shots += 1.
  - EXTEND, on tick: if harpoon_y <= HARPOON_SPEED, set harpoon_y = 0, harpoon_active = 0, go to COOLDOWN. Otherwise harpoon_y -= HARPOON_SPEED.
  - EXTEND, on harpoon_hit (any cycle): harpoon_active = 0, go to COOLDOWN, harpoon_y holds.
  - EXTEND, hit and tick in the same cycle: the hit wins and harpoon_y is not updated. Movement still applies.
  - On entry to COOLDOWN, count = 0. Each tick increments count. On the tick where count reaches COOLDOWN_FRAMES-1, go to IDLE and set harpoon_y = FLOOR_Y.
  - fire_req is discarded in EXTEND and COOLDOWN.
  - harpoon_hit is ignored outside EXTEND.
- Asserting reset mid-flight returns every output to its reset value asynchronously. No tick is generated on release, because the sync flops reset to 1.

Test Plan:
- Reset then 10 frames with keycode 0 -> player_x = 304, harpoon_y = 440, harpoon_active = 0, shots = 0 throughout.
- keycode = 04 for 80 frames from 304 -> player_x decreases by 4 per tick and holds at 0 from tick 76. keycode = 07 for 160 frames -> player_x saturates at 608.
- player_x = 304, space pressed for 1 clk, then 74 ticks -> launch tick gives harpoon_x = 320, y = 440, shots = 1. After 73 more ticks y = 2. The 74th tick gives y = 0 and active = 0. 8 further ticks -> IDLE, y = 440.
- Space held continuously across 200 frames -> exactly one launch (shots = 1). Releasing then pressing after cooldown -> shots = 2.
- harpoon_hit issued in the same cycle as the 10th EXTEND tick -> harpoon_y = 386, active = 0, state COOLDOWN. Press space 2 ticks later -> no launch.
- reset_reset_n low for 3 clk mid-EXTEND, asynchronously to the clock -> all outputs return to reset values immediately. No tick is seen on release.
